// File: rtl/pair_stream_checker.sv
// Trajectory monitor for the x/y step-counter stage: init pair, fixed step, hold at limit, constant difference.
// Optional build macro CHK_PARITY_EN adds an LSB parity check on every RUN/SAT sample (fail code 4).
module pair_stream_checker #(
  parameter int unsigned W      = 11,
  parameter int unsigned INIT_X = 2,
  parameter int unsigned INIT_Y = 1,
  parameter int unsigned STEP   = 2,
  parameter int unsigned LIMIT  = 200,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             clr,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output logic             fail,
  output logic [2:0]       fail_code,
  output logic [CNT_W-1:0] step_cnt,
  output logic             sat,
  output logic             tracking
);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SAT  = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam logic [2:0] C_STEP = 3'd1;
  localparam logic [2:0] C_HOLD = 3'd2;
  localparam logic [2:0] C_DIFF = 3'd3;
  localparam logic [2:0] C_PAR  = 3'd4;

  localparam logic [W-1:0] INIT_XW  = W'(INIT_X);
  localparam logic [W-1:0] INIT_YW  = W'(INIT_Y);
  localparam logic [W-1:0] STEP_W   = W'(STEP);
  localparam logic [W-1:0] DIFF_W   = INIT_XW - INIT_YW;
  localparam bit           INIT_SAT = (INIT_X >= LIMIT);

  logic [1:0]       r_state;
  logic [2:0]       r_code;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_prev_x;
  logic [W-1:0]     r_prev_y;
  logic             r_fail;
  logic             r_sat;
  logic             r_tracking;

  logic [1:0]       w_state_nxt;
  logic [2:0]       w_code_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [W-1:0]     w_px_nxt;
  logic [W-1:0]     w_py_nxt;
  logic [W-1:0]     w_diff;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_diff_ok;
  logic             w_par_ok;
  logic             w_is_init;
  logic             w_is_step;
  logic             w_is_hold;
  logic             w_x_ge_lim;

  assign w_diff     = x - y;
  assign w_diff_ok  = (w_diff == DIFF_W);
  assign w_is_init  = (x == INIT_XW) && (y == INIT_YW);
  assign w_is_step  = (x == r_prev_x + STEP_W) && (y == r_prev_y + STEP_W);
  assign w_is_hold  = (x == r_prev_x) && (y == r_prev_y);
  assign w_x_ge_lim = (32'(x) >= LIMIT);
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef CHK_PARITY_EN
  assign w_par_ok = (x[0] == INIT_XW[0]) && (y[0] == INIT_YW[0]);
`else
  assign w_par_ok = 1'b1;
`endif

  // Next-state and datapath update; clr outranks any sample.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_cnt;
    w_px_nxt    = r_prev_x;
    w_py_nxt    = r_prev_y;
    if (clr) begin
      w_state_nxt = S_WAIT;
      w_code_nxt  = 3'd0;
      w_cnt_nxt   = '0;
    end else if (sample_en) begin
      case (r_state)
        S_WAIT: begin
          if (w_is_init) begin
            w_px_nxt    = x;
            w_py_nxt    = y;
            w_cnt_nxt   = '0;
            w_state_nxt = INIT_SAT ? S_SAT : S_RUN;
          end
        end
        S_RUN: begin
          if (!w_diff_ok) begin
            w_state_nxt = S_FAIL;
            w_code_nxt  = C_DIFF;
          end else if (!w_par_ok) begin
            w_state_nxt = S_FAIL;
            w_code_nxt  = C_PAR;
          end else if (w_is_step) begin
            w_px_nxt  = x;
            w_py_nxt  = y;
            w_cnt_nxt = w_cnt_inc;
            if (w_x_ge_lim) w_state_nxt = S_SAT;
          end else if (w_is_init) begin
            w_px_nxt  = x;
            w_py_nxt  = y;
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = S_FAIL;
            w_code_nxt  = C_STEP;
          end
        end
        S_SAT: begin
          if (!w_diff_ok) begin
            w_state_nxt = S_FAIL;
            w_code_nxt  = C_DIFF;
          end else if (!w_par_ok) begin
            w_state_nxt = S_FAIL;
            w_code_nxt  = C_PAR;
          end else if (w_is_hold) begin
            w_state_nxt = S_SAT;
          end else if (w_is_init) begin
            w_px_nxt    = x;
            w_py_nxt    = y;
            w_cnt_nxt   = '0;
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_FAIL;
            w_code_nxt  = C_HOLD;
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered status flags derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_WAIT;
      r_code     <= 3'd0;
      r_cnt      <= '0;
      r_prev_x   <= '0;
      r_prev_y   <= '0;
      r_fail     <= 1'b0;
      r_sat      <= 1'b0;
      r_tracking <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_cnt      <= w_cnt_nxt;
      r_prev_x   <= w_px_nxt;
      r_prev_y   <= w_py_nxt;
      r_fail     <= (w_state_nxt == S_FAIL);
      r_sat      <= (w_state_nxt == S_SAT);
      r_tracking <= (w_state_nxt == S_RUN) || (w_state_nxt == S_SAT);
    end
  end

  assign fail      = r_fail;
  assign fail_code = r_code;
  assign step_cnt  = r_cnt;
  assign sat       = r_sat;
  assign tracking  = r_tracking;

endmodule
